// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: WIDTH-bit operands, DIGIT bits per cycle,
// with a start/done handshake, subtract mode and signed-overflow flag.
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [IW-1:0]    idx_q, idx_d;

  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] psum_nxt;
  logic             accept;
  logic             last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    accept = start && (state_q != RUN);
    last   = (idx_q == IW'(NDIG - 1));
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = accept ? RUN : IDLE;
      RUN:     state_d = last ? DONE : RUN;
      DONE:    state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands shift right so the active digit always sits in the low bits;
  // the partial sum fills from the top and is complete after NDIG shifts.
  always_comb begin
    dsum = {1'b0, a_q[DIGIT-1:0]}
         + {1'b0, b_q[DIGIT-1:0]}
         + {{DIGIT{1'b0}}, carry_q};
    psum_nxt = WIDTH'({dsum[DIGIT-1:0], psum_q} >> DIGIT);
    a_d     = a_q;
    b_d     = b_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    if (accept) begin
      a_d     = a;
      b_d     = sub ? ~b : b;
      carry_d = sub | cin;
      idx_d   = '0;
      psum_d  = '0;
    end else if (state_q == RUN) begin
      a_d     = a_q >> DIGIT;
      b_d     = b_q >> DIGIT;
      carry_d = dsum[DIGIT];
      psum_d  = psum_nxt;
      idx_d   = last ? '0 : idx_q + IW'(1);
      if (last) begin
        sum_d  = psum_nxt;
        cout_d = dsum[DIGIT];
        // carry into the MSB recovered from its sum bit and operand bits
        ovf_d  = dsum[DIGIT-1] ^ a_q[DIGIT-1]
               ^ b_q[DIGIT-1] ^ dsum[DIGIT];
      end
    end
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
    sum  = sum_q;
    cout = cout_q;
    ovf  = ovf_q;
  end

endmodule

// File: doc/digit_serial_adder.md
# digit_serial_adder

Parametrised multi-cycle adder/subtractor that processes a WIDTH-bit operand pair DIGIT bits per clock, carrying between digits through a registered carry. It is the sequential, area-reduced successor to the combinational 4-bit ripple adder. It adds a start/done handshake, a subtract mode and signed-overflow detection, and serves datapaths where wide operands make a full-width ripple chain too long.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be an integer multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH. NDIG = WIDTH/DIGIT.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only when state is IDLE or DONE.
- a  in  WIDTH  operand A; sampled at the accepting edge only.
- b  in  WIDTH  operand B; sampled at the accepting edge only.
- cin  in  1  carry-in; sampled at the accepting edge; ignored when sub=1.
- sub  in  1  0 = A+B+cin; 1 = A−B (A + ~B + 1); sampled at the accepting edge.
- busy  out  1  high while state is RUN.
- done  out  1  one-cycle pulse in the DONE state.
- sum  out  WIDTH  result; updates only at the last-digit edge; held otherwise.
- cout  out  1  carry out of bit WIDTH−1 (sub mode: 1 = no borrow).
- ovf  out  1  signed overflow = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1:
  - Latch a, and b (or ~b if sub=1).
  - Carry register = cin (or 1 if sub=1).
  - Digit index = 0.
  - Go to RUN.
- IDLE with start=0: stay in IDLE. DONE with start=0: go to IDLE.
- RUN, each edge:
  - {c, s} = A[i] + B[i] + carry, where [i] is digit i (bits i·DIGIT+DIGIT−1 .. i·DIGIT).
  - s goes into the partial-sum register at digit i; carry ← c; i ← i+1.
- RUN at i = NDIG−1:
  - Transfer the completed partial sum to sum.
  - cout ← c; ovf ← carry into the MSB of the top digit XOR c.
  - Go to DONE.
- start while in RUN: ignored, with no effect on operands or state.
- Digit index width is clog2(NDIG), minimum 1 bit. The index never exceeds NDIG−1, so it does not wrap mid-operation.
- All arithmetic is unsigned modulo 2^WIDTH. Overflow interpretation is two's complement.

## Timing
- Reset (edge with rst=1, overriding start):
  - state = IDLE; busy=0, done=0, sum=0, cout=0, ovf=0.
  - Internal operands, carry and index are cleared.
- Reset during RUN aborts the operation. sum/cout/ovf read 0 afterwards, and no done pulse is produced.
- Start accepted at edge E0 → busy=1 from after E0 through after edge E0+NDIG−1. Results and done=1 are visible after edge E0+NDIG.
- Latency: NDIG+1 edges from accept to return to IDLE. With DIGIT=WIDTH, NDIG=1: one RUN cycle, then DONE.
- done is high for exactly one cycle. busy and done are never high together.
- Back-to-back: start=1 in the DONE cycle is accepted. done falls and busy rises on the same edge. Sustained throughput is one operation per NDIG+1 cycles.
- a, b, cin and sub may change freely after the accepting edge without affecting the result.

## Test plan
- WIDTH=16, DIGIT=4: start with a=0x000F, b=0x0001, cin=0, sub=0 → busy for 4 cycles, done on the 5th cycle after accept; sum=0x0010, cout=0, ovf=0.
- a=0xFFFF, b=0xFFFF, cin=0 → sum=0xFFFE, cout=1, ovf=0. Repeat with cin=1 → sum=0xFFFF, cout=1.
- a=0x7FFF, b=0x0001 add → sum=0x8000, ovf=1, cout=0. Sub a=0x8000, b=0x0001 → sum=0x7FFF, ovf=1, cout=1.
- Sub cases:
  - a=0x0009, b=0x0004 with cin=0 (cin must be ignored) → sum=0x0005, cout=1.
  - a=0x0000, b=0x0001 → sum=0xFFFF, cout=0, ovf=0.
- Control sequencing:
  - Pulse start mid-RUN with different operands → first result unchanged, second request dropped.
  - Assert start in the DONE cycle → second operation completes NDIG+1 cycles later.
  - Assert rst in RUN cycle 2 → next cycle busy=0, done=0, sum=0, cout=0, ovf=0, and no done pulse follows.
- WIDTH=8, DIGIT=8 and WIDTH=8, DIGIT=1: a=0xA5, b=0x5B → sum=0x00, cout=1 in both. Latency is 2 and 9 edges respectively.
